// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the decode-stage hazard controller: instruction-class
// production/consumption times and pipeline stage indices.
package hazard_ctrl_pkg;

  typedef logic [4:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  // Tuse / Tnew values by instruction class
  localparam int T_PC  = 0;
  localparam int T_ALU = 1;
  localparam int T_DM  = 2;

  // Post-decode stage indices, also the forwarding-select encoding
  localparam int STAGE_E = 1;
  localparam int STAGE_M = 2;
  localparam int STAGE_W = 3;

endpackage

// File: rtl/hazard_stage_reg.sv
// One tracked pipeline entry {wa, tnew}: loads from the previous stage,
// optionally decrementing tnew (saturating at 0), or takes a bubble.
module hazard_stage_reg
  import hazard_ctrl_pkg::*;
#(
  parameter int TW  = 2,
  parameter bit DEC = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          bubble,
  input  reg_addr_t     wa_in,
  input  logic [TW-1:0] tnew_in,
  output reg_addr_t     wa,
  output logic [TW-1:0] tnew
);

  logic [TW-1:0] tnew_next;

  always_comb begin
    tnew_next = tnew_in;
    if (DEC && (tnew_in != '0)) tnew_next = tnew_in - TW'(1);
  end

  // NOTE: state registers use non-blocking assignments so every stage samples
  // its neighbour's pre-edge value; blocking here would collapse the shift chain.
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      wa   <= REG_ZERO;
      tnew <= '0;
    end else begin
      wa   <= wa_in;
      tnew <= tnew_next;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage stall/forward controller: tracks Tnew of in-flight destinations
// against Tuse of the D-stage sources, plus a HI/LO interlock on mult/div.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int NSTAGE = 3,
  parameter int TW     = 2,
  parameter int MD_LAT = 5,
  localparam int SW    = $clog2(NSTAGE + 1),
  localparam int MW    = $clog2(MD_LAT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    rs_d,
  input  logic [4:0]    rt_d,
  input  logic          use_rs_d,
  input  logic          use_rt_d,
  input  logic [TW-1:0] tuse_rs_d,
  input  logic [TW-1:0] tuse_rt_d,
  input  logic [4:0]    wa_d,
  input  logic [TW-1:0] tnew_d,
  input  logic          md_start_d,
  input  logic          md_use_d,
  output logic          stall,
  output logic [SW-1:0] fwd_rs_sel,
  output logic [SW-1:0] fwd_rt_sel,
  output logic          md_busy
);

  // Index 0 is the D-stage producer; index k is the entry held in stage k.
  reg_addr_t     wa_chain   [0:NSTAGE];
  logic [TW-1:0] tnew_chain [0:NSTAGE];

  assign wa_chain[0]   = wa_d;
  assign tnew_chain[0] = tnew_d;

  for (genvar k = 1; k <= NSTAGE; k++) begin : g_stage
    hazard_stage_reg #(
      .TW (TW),
      .DEC(k > 1)
    ) u_stage (
      .clk    (clk),
      .reset  (reset),
      .bubble ((k == 1) ? stall : 1'b0),
      .wa_in  (wa_chain[k-1]),
      .tnew_in(tnew_chain[k-1]),
      .wa     (wa_chain[k]),
      .tnew   (tnew_chain[k])
    );
  end

  logic          hit_rs, hit_rt;
  logic [TW-1:0] tnew_rs, tnew_rt;
  logic [SW-1:0] sel_rs, sel_rt;
  logic          stall_rs, stall_rt, stall_md;
  logic [MW-1:0] md_cnt;

  // NOTE: every output of this block gets a default before the search loop,
  // otherwise a path with no match would infer a latch.
  always_comb begin
    hit_rs  = 1'b0;
    hit_rt  = 1'b0;
    tnew_rs = '0;
    tnew_rt = '0;
    sel_rs  = '0;
    sel_rt  = '0;
    // Walk oldest to youngest so the youngest match is the one left standing.
    for (int k = NSTAGE; k >= 1; k--) begin
      if (wa_chain[k] != REG_ZERO && wa_chain[k] == rs_d) begin
        hit_rs  = 1'b1;
        tnew_rs = tnew_chain[k];
        sel_rs  = SW'(k);
      end
      if (wa_chain[k] != REG_ZERO && wa_chain[k] == rt_d) begin
        hit_rt  = 1'b1;
        tnew_rt = tnew_chain[k];
        sel_rt  = SW'(k);
      end
    end
    stall_rs   = use_rs_d && (rs_d != REG_ZERO) && hit_rs && (tnew_rs > tuse_rs_d);
    stall_rt   = use_rt_d && (rt_d != REG_ZERO) && hit_rt && (tnew_rt > tuse_rt_d);
    stall_md   = md_use_d && (md_cnt != '0);
    stall      = stall_rs | stall_rt | stall_md;
    fwd_rs_sel = (hit_rs && tnew_rs == '0) ? sel_rs : '0;
    fwd_rt_sel = (hit_rt && tnew_rt == '0) ? sel_rt : '0;
  end

  // The counter only loads when the mult/div actually leaves D.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (md_start_d && !stall) begin
      md_cnt <= MW'(MD_LAT);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - MW'(1);
    end
  end

  assign md_busy = (md_cnt != '0);

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised stall/forward controller for the pipelined MIPS core, sitting beside the decode stage. It tracks each in-flight instruction's destination register and remaining production time (Tnew) across NSTAGE post-decode stages. It compares these against the consumption time (Tuse) of the instruction in D to raise a decode stall and select a forwarding source. It also interlocks HI/LO consumers against a multi-cycle mult/div unit.

## Interface
Parameters:
- NSTAGE, default 3: number of tracked stages after D (1 = E, 2 = M, 3 = W).
- TW, default 2: width of Tnew/Tuse fields.
- MD_LAT, default 5: mult/div busy cycles after issue; must be at least 1.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- rs_d, rt_d  in  5 each  source register numbers of the instruction in D.
- use_rs_d, use_rt_d  in  1 each  the source is actually read.
- tuse_rs_d, tuse_rt_d  in  TW each  cycles until the value is consumed (0 = consumed in D).
- wa_d  in  5  destination register of the instruction in D (0 = none).
- tnew_d  in  TW  cycles until the result exists, counted from entry into E.
- md_start_d  in  1  the instruction in D starts mult/div.
- md_use_d  in  1  the instruction in D reads or writes HI/LO, or starts mult/div.
- stall  out  1  hold PC and the D register, and inject a bubble into E.
- fwd_rs_sel, fwd_rt_sel  out  $clog2(NSTAGE+1) each  forward source stage (0 = register file).
- md_busy  out  1  the mult/div unit is busy.

## Operation
- State per stage k (1..NSTAGE) is {wa[k], tnew[k]}. There is also one mult/div counter md_cnt, $clog2(MD_LAT+1) bits wide.
- Advance every cycle that is not in reset:
  - Stage 1 loads {wa_d, tnew_d}, or {0, 0} (a bubble) when stall is high.
  - Stage k > 1 loads {wa[k-1], sat_dec(tnew[k-1])}.
  - sat_dec(x) = x > 0 ? x-1 : 0.
- For each source s in {rs, rt}:
  - The youngest match is the lowest k with wa[k] == s_d and wa[k] != 0. Only the youngest match is considered; older matches are shadowed.
  - stall_s = use_s_d && (s_d != 0) && the youngest match exists && tnew[k] > tuse_s_d.
  - fwd_s_sel = k if the youngest match exists and tnew[k] == 0; otherwise 0. This does not depend on use_s_d.
- stall_md = md_use_d && (md_cnt != 0).
- stall = stall_rs | stall_rt | stall_md.
- Mult/div counter:
  - If md_start_d && !stall, md_cnt <= MD_LAT.
  - Otherwise, if md_cnt != 0, md_cnt <= md_cnt - 1.
  - md_busy = (md_cnt != 0).
- Register 0 never stalls and never forwards.

## Timing
- Reset: all wa, tnew and md_cnt are cleared. Consequently stall = 0, fwd_*_sel = 0 and md_busy = 0 during and after reset until new entries arrive.
- stall and fwd_*_sel are combinational from the D inputs and registered state, so they are valid in the same cycle.
- State updates on posedge clk. A stalled instruction re-evaluates in the next cycle against the advanced state.
- A producer with tnew_d = t and a consumer with tuse u issued directly behind it stalls for max(0, t-u) cycles.
- mult/div followed by a HI/LO user: the user stalls for MD_LAT cycles.
- An md_start_d that coincides with a register stall does not load the counter; it loads on the cycle it actually issues.
- Reset asserted during a stall: stall drops the following cycle and the pipeline state is empty.

## Structure
- The shared package holds the instruction-class Tuse/Tnew constants: T_PC = 0, T_ALU = 1, T_DM = 2. It also holds the stage index constants (E = 1, M = 2, W = 3).
- One sub-module, hazard_stage_reg: holds one {wa, tnew} entry with bubble-load and saturating decrement. It is instantiated NSTAGE times in a generate loop.
- Comparison, stall and forward logic and md_cnt live in the top module.

## Test plan
- lw $8 (tnew_d = 2), then addu reading $8 with tuse 1: stall is high for exactly 1 cycle. On the next cycle stall = 0, and fwd_rs_sel = 0 because the producer is not yet ready.
- addu writing $9 (tnew_d = 1), then beq reading $9 with tuse 0: stall is high for 1 cycle, then fwd_rs_sel = 2 (M).
- ori writing $0, then a consumer of $0: stall = 0 and fwd = 0 throughout.
- A producer of $5 in E (tnew 1) and an older producer of $5 in M (tnew 0), with a consumer at tuse 0: the consumer stalls, showing the youngest entry wins over the ready older entry.
- mult, then mfhi with MD_LAT = 5: stall and md_busy are high for 5 cycles, then mfhi issues.
- Reset asserted mid-stall from the first scenario: all outputs are 0 the cycle after reset.
